fractcam_pe: RTL and testbench

//  Next-generation FracTCAM: parametrised ternary CAM of arbitrary width and depth.
//  - Each entry is stored as 32-bit truth tables (one per 5-bit key slice, LUTRAM-style).
//  - Includes a rule-programming FSM that expands value/mask into those tables.
//  - Pipelined search path returns the match vector plus a lowest-index priority encode.
//  - Sits between the control plane (rule writes) and the packet classifier (search keys).

---
 rtl/fractcam_pe.sv | 178 +++++++++++++++++
 tb/tb_fractcam_pe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fractcam_pe.sv
// fractcam_pe: ternary CAM built from 32-entry truth tables, one table per
// 5-bit key slice per entry. A write FSM expands value/mask rules into the
// tables. A three-stage search pipeline returns the per-entry match vector,
// the hit flag and the lowest matching index.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   search_valid/search_key  one lookup per cycle, no backpressure
//   match_valid              result strobe, 3 cycles after search_valid
//   match/match_hit/match_index  result fields, held while match_valid=0
//   wr_valid/wr_ready        rule command handshake (ready = FSM idle)
//   wr_del/wr_addr/wr_value/wr_mask  command: delete or program entry
//   wr_done/wr_err           completion pulse, error when wr_addr out of range
module fractcam_pe #(
  parameter int TCAM_WIDTH = 16,
  parameter int TCAM_DEPTH = 64,
  parameter int ADDR_WIDTH = $clog2(TCAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  search_valid,
  input  logic [TCAM_WIDTH-1:0] search_key,
  output logic                  match_valid,
  output logic [TCAM_DEPTH-1:0] match,
  output logic                  match_hit,
  output logic [ADDR_WIDTH-1:0] match_index,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_del,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [TCAM_WIDTH-1:0] wr_value,
  input  logic [TCAM_WIDTH-1:0] wr_mask,
  output logic                  wr_done,
  output logic                  wr_err
);

  localparam int COLS  = (TCAM_WIDTH + 4) / 5;
  localparam int KEY_W = COLS * 5;

  typedef enum logic [1:0] {IDLE, PROG, DONE} state_t;

  // Truth bit for table address a: every care bit of the slice must agree.
  // Pad bits arrive with mask 0 and are therefore don't-care.
  function automatic logic tt_bit(input logic [4:0] v, input logic [4:0] m,
                                  input logic [4:0] a);
    logic r;
    r = 1'b1;
    for (int b = 0; b < 5; b++) r = r & (~m[b] | (a[b] == v[b]));
    return r;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] lowest_idx(input logic [TCAM_DEPTH-1:0] v);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int i = TCAM_DEPTH - 1; i >= 0; i--) if (v[i]) r = ADDR_WIDTH'(i);
    return r;
  endfunction

  logic [31:0]           tt [TCAM_DEPTH][COLS];
  logic [TCAM_DEPTH-1:0] valid_q;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  del_q, err_q;
  logic [KEY_W-1:0]      value_q, mask_q;
  logic                  addr_bad;

  logic                  vld_p1, vld_p2;
  logic [KEY_W-1:0]      key_p1;
  logic [TCAM_DEPTH-1:0] hit_vec, match_p2;

  // ---- S1: register key and valid ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= search_valid;
  end

  always_ff @(posedge clk) key_p1 <= KEY_W'(search_key);

  // ---- S2: table lookup per column, AND across columns, gate by valid ----
  always_comb begin
    hit_vec = '0;
    for (int e = 0; e < TCAM_DEPTH; e++) begin
      hit_vec[e] = valid_q[e];
      for (int c = 0; c < COLS; c++)
        hit_vec[e] = hit_vec[e] & tt[e][c][key_p1[c*5 +: 5]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p2 <= 1'b0;
    else      vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) match_p2 <= hit_vec;

  // ---- S3: result registers, updated only for valid lookups ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_valid <= 1'b0;
      match       <= '0;
      match_hit   <= 1'b0;
      match_index <= '0;
    end else begin
      match_valid <= vld_p2;
      if (vld_p2) begin
        match       <= match_p2;
        match_hit   <= |match_p2;
        match_index <= lowest_idx(match_p2);
      end
    end
  end

  // ---- Write FSM ----
  assign wr_ready = (state_q == IDLE);
  assign addr_bad = ({1'b0, wr_addr} >= (ADDR_WIDTH+1)'(TCAM_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_valid) state_d = (addr_bad || wr_del) ? DONE : PROG;
      PROG:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The entry is invalidated on accept so no search sees half-written
  // tables; its valid bit is restored on the edge that raises wr_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      del_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      case (state_q)
        IDLE: if (wr_valid) begin
          addr_q <= wr_addr;
          del_q  <= wr_del;
          err_q  <= addr_bad;
          cnt_q  <= '0;
          if (!addr_bad && !wr_del) valid_q[wr_addr] <= 1'b0;
        end
        PROG: cnt_q <= cnt_q + 5'd1;
        DONE: begin
          wr_done <= 1'b1;
          wr_err  <= err_q;
          if (!err_q) valid_q[addr_q] <= ~del_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ready && wr_valid) begin
      value_q <= KEY_W'(wr_value);
      mask_q  <= KEY_W'(wr_mask);
    end
  end

  // One table address per cycle, all columns of the entry in parallel.
  always_ff @(posedge clk) begin
    if (state_q == PROG)
      for (int c = 0; c < COLS; c++)
        tt[addr_q][c][cnt_q] <= tt_bit(value_q[c*5 +: 5], mask_q[c*5 +: 5], cnt_q);
  end

endmodule

// File: tb/tb_fractcam_pe.sv
// Directed bench for fractcam_pe: a 16x64 instance for the main checks and
// a 7x12 instance for key/depth padding and out-of-range writes.
module tb_fractcam_pe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 16-bit x 64-entry instance
  logic        s_valid = 1'b0;
  logic [15:0] s_key = '0;
  logic        m_valid, m_hit;
  logic [63:0] m_vec;
  logic [5:0]  m_idx;
  logic        w_valid = 1'b0, w_del = 1'b0;
  logic        w_ready, w_done, w_err;
  logic [5:0]  w_addr = '0;
  logic [15:0] w_value = '0, w_mask = '0;

  // 7-bit x 12-entry instance
  logic        t_s_valid = 1'b0;
  logic [6:0]  t_s_key = '0;
  logic        t_m_valid, t_m_hit;
  logic [11:0] t_m_vec;
  logic [3:0]  t_m_idx;
  logic        t_w_valid = 1'b0, t_w_del = 1'b0;
  logic        t_w_ready, t_w_done, t_w_err;
  logic [3:0]  t_w_addr = '0;
  logic [6:0]  t_w_value = '0, t_w_mask = '0;

  int n_chk = 0;
  int n_bad = 0;

  fractcam_pe #(.TCAM_WIDTH(16), .TCAM_DEPTH(64)) u_dut (
    .clk(clk), .rst(rst),
    .search_valid(s_valid), .search_key(s_key),
    .match_valid(m_valid), .match(m_vec), .match_hit(m_hit), .match_index(m_idx),
    .wr_valid(w_valid), .wr_ready(w_ready), .wr_del(w_del), .wr_addr(w_addr),
    .wr_value(w_value), .wr_mask(w_mask), .wr_done(w_done), .wr_err(w_err)
  );

  fractcam_pe #(.TCAM_WIDTH(7), .TCAM_DEPTH(12)) u_dut_s (
    .clk(clk), .rst(rst),
    .search_valid(t_s_valid), .search_key(t_s_key),
    .match_valid(t_m_valid), .match(t_m_vec), .match_hit(t_m_hit), .match_index(t_m_idx),
    .wr_valid(t_w_valid), .wr_ready(t_w_ready), .wr_del(t_w_del), .wr_addr(t_w_addr),
    .wr_value(t_w_value), .wr_mask(t_w_mask), .wr_done(t_w_done), .wr_err(t_w_err)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic search(input string tag, input logic [15:0] key,
                        input logic [63:0] exp_vec, input logic [5:0] exp_idx);
    s_valid = 1'b1; s_key = key;
    tick();
    s_valid = 1'b0;
    tick();
    chk_eq({tag, ".early"}, m_valid, 1'b0);
    tick();
    chk_eq({tag, ".vld"}, m_valid, 1'b1);
    chk_eq({tag, ".vec"}, m_vec, exp_vec);
    chk_eq({tag, ".hit"}, m_hit, exp_vec != 64'd0);
    chk_eq({tag, ".idx"}, m_idx, exp_idx);
  endtask

  task automatic wcmd(input string tag, input logic del, input logic [5:0] addr,
                      input logic [15:0] v, input logic [15:0] m, input int exp_lat);
    int cyc;
    chk_eq({tag, ".rdy"}, w_ready, 1'b1);
    w_valid = 1'b1; w_del = del; w_addr = addr; w_value = v; w_mask = m;
    tick();
    w_valid = 1'b0;
    cyc = 1;
    chk_eq({tag, ".busy"}, w_ready, 1'b0);
    while (w_done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk_eq({tag, ".lat"}, cyc, exp_lat);
    chk_eq({tag, ".err"}, w_err, 1'b0);
  endtask

  task automatic ssearch(input string tag, input logic [6:0] key,
                         input logic [11:0] exp_vec, input logic [3:0] exp_idx);
    t_s_valid = 1'b1; t_s_key = key;
    repeat (3) begin
      tick();
      t_s_valid = 1'b0;
    end
    chk_eq({tag, ".vld"}, t_m_valid, 1'b1);
    chk_eq({tag, ".vec"}, t_m_vec, exp_vec);
    chk_eq({tag, ".hit"}, t_m_hit, exp_vec != 12'd0);
    chk_eq({tag, ".idx"}, t_m_idx, exp_idx);
  endtask

  task automatic sprog(input string tag, input logic [3:0] addr, input logic [6:0] v,
                       input logic [6:0] m, input int exp_lat, input logic exp_err);
    int cyc;
    chk_eq({tag, ".rdy"}, t_w_ready, 1'b1);
    t_w_valid = 1'b1; t_w_addr = addr; t_w_value = v; t_w_mask = m;
    tick();
    t_w_valid = 1'b0;
    cyc = 1;
    while (t_w_done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk_eq({tag, ".lat"}, cyc, exp_lat);
    chk_eq({tag, ".err"}, t_w_err, exp_err);
  endtask

  initial begin
    logic [63:0] exp_vec;

    // Reset state
    repeat (3) tick();
    chk_eq("rst.vld", m_valid, 1'b0);
    chk_eq("rst.vec", m_vec, 64'd0);
    chk_eq("rst.hit", m_hit, 1'b0);
    chk_eq("rst.idx", m_idx, 6'd0);
    chk_eq("rst.rdy", w_ready, 1'b1);
    chk_eq("rst.done", w_done, 1'b0);
    chk_eq("rst.err", w_err, 1'b0);
    chk_eq("rst.s_rdy", t_w_ready, 1'b1);
    rst = 1'b1;
    tick();

    // Empty table never hits
    search("t1", 16'hABCD, 64'd0, 6'd0);

    // Exact rule
    wcmd("t2.prog5", 1'b0, 6'd5, 16'h1234, 16'hFFFF, 34);
    search("t2.hit", 16'h1234, 64'd1 << 5, 6'd5);
    search("t2.miss", 16'h1235, 64'd0, 6'd0);

    // Overlapping rules, priority, delete
    wcmd("t3.prog9", 1'b0, 6'd9, 16'h1200, 16'hFF00, 34);
    search("t3.both", 16'h1234, (64'd1 << 5) | (64'd1 << 9), 6'd5);
    search("t3.only9", 16'h12FF, 64'd1 << 9, 6'd9);
    wcmd("t3.del5", 1'b1, 6'd5, 16'h0000, 16'h0000, 2);
    search("t3.after", 16'h1234, 64'd1 << 9, 6'd9);

    // Keys every cycle while e3 is programmed; result at cycle k comes from
    // the key of cycle k-3 whose table lookup happened in cycle k-2.
    chk_eq("t4.rdy", w_ready, 1'b1);
    w_valid = 1'b1; w_del = 1'b0; w_addr = 6'd3; w_value = 16'h00AA; w_mask = 16'h00FF;
    s_valid = 1'b1; s_key = 16'h12AA;
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k == 1) w_valid = 1'b0;
      if (k == 42) s_valid = 1'b0;
      chk_eq($sformatf("t4.done%0d", k), w_done, k == 34);
      if (k >= 3) begin
        exp_vec = (64'd1 << 9) | ((k >= 36) ? (64'd1 << 3) : 64'd0);
        chk_eq($sformatf("t4.vld%0d", k), m_valid, 1'b1);
        chk_eq($sformatf("t4.vec%0d", k), m_vec, exp_vec);
        chk_eq($sformatf("t4.idx%0d", k), m_idx, (k >= 36) ? 6'd3 : 6'd9);
      end
    end
    tick();

    // All-don't-care rule matches everything
    wcmd("t4.prog60", 1'b0, 6'd60, 16'hFFFF, 16'h0000, 34);
    search("t4.any0", 16'h0000, 64'd1 << 60, 6'd60);
    search("t4.any1", 16'h12AA, (64'd1 << 3) | (64'd1 << 9) | (64'd1 << 60), 6'd3);

    // Padded geometry and out-of-range write
    sprog("t5.prog11", 4'd11, 7'h55, 7'h7F, 34, 1'b0);
    ssearch("t5.hit", 7'h55, 12'h800, 4'd11);
    ssearch("t5.miss", 7'h54, 12'h000, 4'd0);
    sprog("t5.bad", 4'd12, 7'h54, 7'h7F, 2, 1'b1);
    ssearch("t5.nochg", 7'h54, 12'h000, 4'd0);
    ssearch("t5.keep", 7'h55, 12'h800, 4'd11);

    // Reset in the middle of programming
    chk_eq("t6.rdy", w_ready, 1'b1);
    w_valid = 1'b1; w_del = 1'b0; w_addr = 6'd7; w_value = 16'hBEEF; w_mask = 16'hFFFF;
    tick();
    w_valid = 1'b0;
    repeat (10) tick();
    chk_eq("t6.pre_hit", m_hit, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_eq("t6.vld", m_valid, 1'b0);
    chk_eq("t6.vec", m_vec, 64'd0);
    chk_eq("t6.hit", m_hit, 1'b0);
    chk_eq("t6.idx", m_idx, 6'd0);
    chk_eq("t6.rdy_now", w_ready, 1'b1);
    chk_eq("t6.done", w_done, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    search("t6.miss7", 16'hBEEF, 64'd0, 6'd0);
    search("t6.miss9", 16'h12AA, 64'd0, 6'd0);
    wcmd("t6.reprog", 1'b0, 6'd7, 16'hBEEF, 16'hFFFF, 34);
    search("t6.hit7", 16'hBEEF, 64'd1 << 7, 6'd7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
